// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I writeback widths and source-select type
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter for ALU/LSU writeback
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_alu, req_lsu  requests from the two writeback sources
//   gnt_alu, gnt_lsu  one-hot grant (combinational)
//   gnt_src           which source is granted (valid when either grant is high)
module rr_arbiter2
    import rv32i_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu,
    output src_e gnt_src
);

    src_e ptr_q;
    src_e ptr_d;

    always_comb begin
        gnt_src = SRC_ALU;
        if (req_alu && req_lsu) begin
            gnt_src = ptr_q;
        end else if (req_lsu) begin
            gnt_src = SRC_LSU;
        end
        gnt_alu = req_alu && (gnt_src == SRC_ALU);
        gnt_lsu = req_lsu && (gnt_src == SRC_LSU);

        // Any grant, contended or not, hands priority to the other source.
        ptr_d = ptr_q;
        if (req_alu || req_lsu) begin
            ptr_d = other_src(gnt_src);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - RV32I scoreboard and register-file write-port scheduler
// Ports:
//   sysclk, sysreset_n            clock, asynchronous active-low reset
//   issue_*                       decode handshake; issue_ready stalls on RAW/WAW
//   alu_wb_*, lsu_wb_*            writeback sources, ready = granted this cycle
//   rf_we/rf_rd_addr/rf_rd_data   registered register-file write port
//   busy_mask                     bit i set while a write to xi is outstanding
module regfile_wb_scheduler
    import rv32i_pkg::*;
(
    input  logic                  sysclk,
    input  logic                  sysreset_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1_addr,
    input  logic [REG_ADDR_W-1:0] issue_rs2_addr,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr,
    input  logic                  issue_rd_we,
    output logic                  issue_ready,
    input  logic                  alu_wb_valid,
    input  logic [REG_ADDR_W-1:0] alu_wb_rd,
    input  logic [XLEN-1:0]       alu_wb_data,
    output logic                  alu_wb_ready,
    input  logic                  lsu_wb_valid,
    input  logic [REG_ADDR_W-1:0] lsu_wb_rd,
    input  logic [XLEN-1:0]       lsu_wb_data,
    output logic                  lsu_wb_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_rd_data,
    output logic [NUM_REGS-1:0]   busy_mask
);

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [XLEN-1:0]       rf_rd_data_q, rf_rd_data_d;

    logic                  gnt_alu, gnt_lsu, gnt_any;
    src_e                  gnt_src;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  rs1_hz, rs2_hz, rd_hz;
    logic                  issue_set;

    rr_arbiter2 u_arb (
        .clk     (sysclk),
        .rst_n   (sysreset_n),
        .req_alu (alu_wb_valid),
        .req_lsu (lsu_wb_valid),
        .gnt_alu (gnt_alu),
        .gnt_lsu (gnt_lsu),
        .gnt_src (gnt_src)
    );

    always_comb begin
        gnt_any = gnt_alu || gnt_lsu;
        wb_rd   = (gnt_src == SRC_LSU) ? lsu_wb_rd   : alu_wb_rd;
        wb_data = (gnt_src == SRC_LSU) ? lsu_wb_data : alu_wb_data;

        // Hazards look at pre-edge busy, so a register being released this
        // edge still stalls for one more cycle.
        rs1_hz      = (issue_rs1_addr != '0) && busy_q[issue_rs1_addr];
        rs2_hz      = (issue_rs2_addr != '0) && busy_q[issue_rs2_addr];
        rd_hz       = issue_rd_we && (issue_rd_addr != '0) && busy_q[issue_rd_addr];
        issue_ready = !rs1_hz && !rs2_hz && !rd_hz;
        issue_set   = issue_valid && issue_ready && issue_rd_we && (issue_rd_addr != '0);

        // Set is evaluated after clear so a same-edge issue of the same rd wins.
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (gnt_any && (wb_rd == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (issue_set && (issue_rd_addr == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;

        rf_we_d      = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        rf_rd_data_d = rf_rd_data_q;
        if (gnt_any) begin
            rf_we_d      = (wb_rd != '0);
            rf_rd_addr_d = wb_rd;
            rf_rd_data_d = wb_data;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            busy_q       <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_data_q <= '0;
        end else begin
            busy_q       <= busy_d;
            rf_we_q      <= rf_we_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_rd_data_q <= rf_rd_data_d;
        end
    end

    assign alu_wb_ready = gnt_alu;
    assign lsu_wb_ready = gnt_lsu;
    assign rf_we        = rf_we_q;
    assign rf_rd_addr   = rf_rd_addr_q;
    assign rf_rd_data   = rf_rd_data_q;
    assign busy_mask    = busy_q;

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Scoreboard and write-port scheduler for the RV32I register file. It tracks registers with a write outstanding and stalls issue on RAW or WAW hazards. It round-robin arbitrates the single register-file write port between the ALU and LSU writeback sources. It drives the register file's we/rd_addr/rd_data from a registered output stage.

Parameters:
XLEN, 32, data width of writeback data.
REG_ADDR_W, 5, register address width.
NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W).

Ports:
sysclk  in  1  system clock; all state updates on rising edge
sysreset_n  in  1  asynchronous, active-low reset
issue_valid  in  1  decode presents an instruction
issue_rs1_addr  in  REG_ADDR_W  source 1 register
issue_rs2_addr  in  REG_ADDR_W  source 2 register
issue_rd_addr  in  REG_ADDR_W  destination register
issue_rd_we  in  1  instruction writes rd
issue_ready  out  1  no hazard; issue accepted when valid&&ready
alu_wb_valid  in  1  ALU result available
alu_wb_rd  in  REG_ADDR_W  ALU destination
alu_wb_data  in  XLEN  ALU result
alu_wb_ready  out  1  ALU writeback granted this cycle
lsu_wb_valid  in  1  load data available
lsu_wb_rd  in  REG_ADDR_W  load destination
lsu_wb_data  in  XLEN  load data
lsu_wb_ready  out  1  LSU writeback granted this cycle
rf_we  out  1  register-file write enable (registered)
rf_rd_addr  out  REG_ADDR_W  register-file write address (registered)
rf_rd_data  out  XLEN  register-file write data (registered)
busy_mask  out  NUM_REGS  scoreboard state, bit i = write pending on xi

Behaviour:
- Reset, asynchronous on sysreset_n low:
  - busy_mask = 0; rf_we = 0; rf_rd_addr = 0; rf_rd_data = 0.
  - Round-robin pointer favours ALU.
  - Takes effect immediately, mid-cycle included; an in-flight grant is discarded.
- Scoreboard:
  - busy_mask[0] is hardwired 0.
  - An issue handshake with issue_rd_we=1 and rd!=0 sets busy[rd] at the next edge.
  - An accepted writeback clears busy[rd] at the same edge that loads the output register.
  - Same-edge set and clear of the same rd: set wins.
- issue_ready (combinational) = !(rs1!=0 && busy[rs1]) && !(rs2!=0 && busy[rs2]) && !(issue_rd_we && rd!=0 && busy[rd]).
  - Evaluated on pre-edge busy; a register clearing this edge still stalls this cycle.
  - Independent of issue_valid.
- Arbitration, one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: the pointer's source is granted, and the pointer moves to the other source.
  - A single-requester grant also moves the pointer to the other source.
  - ready is combinational and asserted only to the granted source; the source must hold valid/rd/data stable until ready.
- Output stage:
  - On grant, rf_we <= (rd!=0), rf_rd_addr <= rd, rf_rd_data <= data at the next rising edge.
  - With no grant, rf_we <= 0; addr and data hold their values.
  - Latency is 1 cycle grant-to-rf_we.
  - The register file commits at the following falling edge, so the cycle in which busy clears can read the new value.
- rd=0 writeback: handshake completes, rf_we stays 0, busy unchanged.
- Writeback to a non-busy register: still written, busy unchanged (no error).

Decomposition:
- Shared package rv32i_pkg holds XLEN, REG_ADDR_W, NUM_REGS and a source-select enum {SRC_ALU, SRC_LSU}.
- One sub-module: rr_arbiter2 (2-way round-robin with pointer flop).
- Scoreboard and output stage stay in the top module.

Test Plan:
- Reset: drive sysreset_n low, then high, with issue_valid=1, rs1=1, rs2=2, rd=3 -> busy_mask=0, rf_we=0, issue_ready=1. The next edge sets busy_mask=0x0000_0008.
- RAW: issue rd=5, then present rs1=5 -> issue_ready=0.
  - Then ALU valid, rd=5, data=0xDEADBEEF -> alu_wb_ready=1.
  - Next cycle: rf_we=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF, busy[5]=0, issue_ready=1.
- Fairness: ALU (rd=3) and LSU (rd=4) both valid for 4 cycles -> grants ALU, LSU, ALU, LSU; rf_rd_addr sequence 3, 4, 3, 4.
- x0: LSU valid, rd=0, data=0x1234 -> lsu_wb_ready=1, rf_we remains 0, busy_mask unchanged.
- WAW: busy[7]=1, issue rd=7 with rd_we=1 and rs1=rs2=0 -> issue_ready=0. With rd_we=0 -> issue_ready=1.
- Async reset mid-operation: busy_mask=0x0000_0060 and rf_we=1, pull sysreset_n low between edges -> busy_mask=0 and rf_we=0 immediately, with no clock edge.
